div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider in the EXE stage; handles the DIV and DIVU ALU operations.
- The ALU control decoder selects DIV/DIVU. The EXE-stage control raises start for those ops and stalls the pipeline while start=1 and ready=0.
- Result goes to the HI/LO write path: HI = remainder, LO = quotient.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_unit.sv | 130 +++++++++++++
 tb/tb_div_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the EXE-stage multi-cycle divider.
// State encodings, handshake levels and the iteration count.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int DivIters = 32;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle.
// result = {remainder, quotient}, registered and valid while ready=1.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DivIters
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] Last = CW'(WIDTH - 1);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sdiv_q;
  logic             s1_q;
  logic             s2_q;
  logic [2*WIDTH-1:0] result_q;
  logic             ready_q;

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  function automatic logic [WIDTH:0] trial_sub(
    input logic [WIDTH:0]   a,
    input logic [WIDTH-1:0] b
  );
    return a - {1'b0, b};
  endfunction

  always_comb begin
    sh    = {rem_q, dvd_q[WIDTH-1]};
    diff  = trial_sub(sh, dvs_q);
    rem_d = sh[WIDTH-1:0];
    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
    end
    // Quotient sign from the XOR of signs; remainder follows the dividend.
    quo_fix = (sdiv_q && (s1_q ^ s2_q)) ? -dvd_d : dvd_d;
    rem_fix = (sdiv_q && s1_q) ? -rem_d : rem_d;
    a_abs = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    b_abs = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sdiv_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          if (start == DivStart && !annul) begin
            sdiv_q <= signed_div;
            s1_q   <= opdata1[WIDTH-1];
            s2_q   <= opdata2[WIDTH-1];
            dvd_q  <= a_abs;
            dvs_q  <= b_abs;
            rem_q  <= '0;
            cnt_q  <= '0;
            state_q <= (opdata2 == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (annul) begin
            state_q <= DivFree;
          end else begin
            result_q <= '0;
            ready_q  <= DivResultReady;
            state_q  <= DivEnd;
          end
        end
        DivOn: begin
          if (annul) begin
            state_q <= DivFree;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == Last) begin
              result_q <= {rem_fix, quo_fix};
              ready_q  <= DivResultReady;
              state_q  <= DivEnd;
            end
          end
        end
        DivEnd: begin
          // Start must drop before a new accept, so END never loops back.
          if (annul || start == DivStop) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus annul/reset/handshake cases.
// Expected values are hand-computed constants.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_chk  = 0;
  int n_fail = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .resetn(resetn),
    .signed_div(signed_div),
    .opdata1(opdata1),
    .opdata2(opdata2),
    .start(start),
    .annul(annul),
    .result(result),
    .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sdiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rem;
    logic [31:0] quo;
    int          edges;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept at the next edge, scramble operands afterwards, wait for ready.
  task automatic run_op(input vec_t v, input bit scramble,
                        output int edges);
    @(negedge clk);
    signed_div = v.sdiv;
    opdata1 = v.a;
    opdata2 = v.b;
    start = 1'b1;
    edges = 0;
    while (edges < 40) begin
      step();
      edges++;
      if (edges == 1 && scramble) begin
        opdata1 = 32'hDEAD_BEEF;
        opdata2 = 32'h0000_0003;
        signed_div = ~v.sdiv;
      end
      if (ready) break;
    end
    if (!ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: ready=%b after %0d edges", v.name,
               ready, edges);
    end
  endtask

  task automatic drop_start(input string nm);
    @(negedge clk);
    start = 1'b0;
    step();
    chk({nm, " ready after drop"}, {63'd0, ready}, 64'd0);
    chk({nm, " result after drop"}, result, 64'd0);
  endtask

  initial begin
    int   e;
    vec_t v;
    logic [63:0] held;

    vecs.push_back('{"divu 100/7", 1'b0, 32'd100, 32'd7,
                     32'h2, 32'hE, 33});
    vecs.push_back('{"div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2,
                     32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    vecs.push_back('{"div 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE,
                     32'h1, 32'hFFFF_FFFD, 33});
    vecs.push_back('{"div by zero", 1'b1, 32'h1234, 32'h0,
                     32'h0, 32'h0, 2});
    vecs.push_back('{"div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h0, 32'h8000_0000, 33});
    vecs.push_back('{"divu max/1", 1'b0, 32'hFFFF_FFFF, 32'h1,
                     32'h0, 32'hFFFF_FFFF, 33});
    vecs.push_back('{"divu 5/9", 1'b0, 32'd5, 32'd9,
                     32'd5, 32'd0, 33});
    vecs.push_back('{"div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                     32'hFFFF_FFFE, 32'hE, 33});
    vecs.push_back('{"divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h8000_0000, 32'h0, 33});

    resetn = 1'b0;
    signed_div = 1'b0;
    opdata1 = '0;
    opdata2 = '0;
    start = 1'b0;
    annul = 1'b0;
    step();
    step();
    chk("reset ready", {63'd0, ready}, 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("idle ready", {63'd0, ready}, 64'd0);

    // Table: back-to-back ops with a one-cycle start gap between them.
    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v, 1'b1, e);
      chk({v.name, " latency"}, 64'(e), 64'(v.edges));
      chk({v.name, " result"}, result, {v.rem, v.quo});
      drop_start(v.name);
    end

    // Start held through END: no second operation.
    v = vecs[0];
    run_op(v, 1'b0, e);
    held = result;
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("held ready", {63'd0, ready}, 64'd1);
      chk("held result", result, held);
    end
    drop_start("held");

    // Annul at iteration 10.
    v = vecs[0];
    @(negedge clk);
    opdata1 = v.a;
    opdata2 = v.b;
    signed_div = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      chk("annul10 no ready", {63'd0, ready}, 64'd0);
    end
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    step();
    chk("annul10 ready", {63'd0, ready}, 64'd0);
    chk("annul10 result", result, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    for (int k = 0; k < 35; k++) begin
      step();
      chk("annul10 stays idle", {63'd0, ready}, 64'd0);
    end

    // Annul exactly on the completing edge E32.
    @(negedge clk);
    start = 1'b1;
    step();
    for (int k = 0; k < 31; k++) step();
    chk("annulE32 pre", {63'd0, ready}, 64'd0);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    step();
    chk("annulE32 ready", {63'd0, ready}, 64'd0);
    chk("annulE32 result", result, 64'd0);
    @(negedge clk);
    annul = 1'b0;

    // Annul in END with start still held.
    run_op(vecs[1], 1'b0, e);
    chk("annulEnd before", result, {vecs[1].rem, vecs[1].quo});
    @(negedge clk);
    annul = 1'b1;
    step();
    chk("annulEnd ready", {63'd0, ready}, 64'd0);
    chk("annulEnd result", result, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    step();

    // A fresh op after annul proves the unit went idle.
    run_op(vecs[2], 1'b1, e);
    chk("post annul latency", 64'(e), 64'd33);
    chk("post annul result", result, {vecs[2].rem, vecs[2].quo});

    // Asynchronous reset while in END: outputs clear without an edge.
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async rst ready", {63'd0, ready}, 64'd0);
    chk("async rst result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;

    // Reset mid-ON discards the op.
    @(negedge clk);
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    for (int k = 0; k < 6; k++) step();
    @(negedge clk);
    resetn = 1'b0;
    start = 1'b0;
    #1;
    chk("rst midON ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 35; k++) begin
      step();
      chk("rst midON idle", {63'd0, ready}, 64'd0);
    end

    run_op(vecs[6], 1'b0, e);
    chk("post rst latency", 64'(e), 64'd33);
    chk("post rst result", result, {vecs[6].rem, vecs[6].quo});
    drop_start("post rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
